gfx_pattern_gen: RTL and testbench

Multi-mode, frame-based test-pattern generator that writes complete frames into the gfx pixel stream (valid/x/y/pixel/ready) feeding the `svc_gfx_vga` framebuffer path. It generalises the single-pattern generator in four ways: parametrised colour depth, runtime mode select, an internal continuous-frame mode and a frame counter that animates patterns. Its `s_gfx_done` pulse drives the framebuffer's `fb_start`.

---
 rtl/gfx_pattern_gen.sv | 184 ++++++++++++++++++
 tb/tb_gfx_pattern_gen.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_pattern_gen.sv
// gfx_pattern_gen: frame-based multi-mode test-pattern generator for the gfx
// pixel stream (valid/x/y/pixel/ready) that feeds the svc_gfx_vga framebuffer.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   s_gfx_start     start one frame (honoured only in IDLE)
//   continuous      sampled in DONE; 1 = start the next frame automatically
//   mode            pattern select, latched at frame start
//   solid_color     base colour for solid/checker, latched at frame start
//   h_visible       frame width, latched at frame start
//   v_visible       frame height, latched at frame start
//   s_gfx_done      one-cycle pulse after the last pixel of a frame
//   busy            high while a frame is being emitted
//   frame_cnt       number of completed frames (wraps)
//   m_gfx_valid/x/y/pixel, m_gfx_ready   pixel stream master
module gfx_pattern_gen #(
  parameter int unsigned H_WIDTH         = 12,
  parameter int unsigned V_WIDTH         = 12,
  parameter int unsigned COLOR_WIDTH     = 4,
  parameter int unsigned PIXEL_WIDTH     = 3 * COLOR_WIDTH,
  parameter int unsigned FRAME_CNT_WIDTH = 8,
  parameter int unsigned BAR_SHIFT       = 6,
  parameter int unsigned CHECK_SHIFT     = 4,
  parameter int unsigned GRAD_SHIFT      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_gfx_start,
  input  logic                       continuous,
  input  logic [2:0]                 mode,
  input  logic [PIXEL_WIDTH-1:0]     solid_color,
  input  logic [H_WIDTH-1:0]         h_visible,
  input  logic [V_WIDTH-1:0]         v_visible,
  output logic                       s_gfx_done,
  output logic                       busy,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  output logic                       m_gfx_valid,
  output logic [H_WIDTH-1:0]         m_gfx_x,
  output logic [V_WIDTH-1:0]         m_gfx_y,
  output logic [PIXEL_WIDTH-1:0]     m_gfx_pixel,
  input  logic                       m_gfx_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [2:0]                 mode_q, mode_d;
  logic [PIXEL_WIDTH-1:0]     solid_q, solid_d;
  logic [H_WIDTH-1:0]         hv_q, hv_d;
  logic [V_WIDTH-1:0]         vv_q, vv_d;
  logic [H_WIDTH-1:0]         x_q, x_d;
  logic [V_WIDTH-1:0]         y_q, y_d;
  logic [FRAME_CNT_WIDTH-1:0] fc_q, fc_d;

  logic dims_ok;
  logic last_x;
  logic last_y;

  assign dims_ok = (h_visible != '0) && (v_visible != '0);
  assign last_x  = (x_q == hv_q - H_WIDTH'(1));
  assign last_y  = (y_q == vv_q - V_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    solid_d = solid_q;
    hv_d    = hv_q;
    vv_d    = vv_q;
    x_d     = x_q;
    y_d     = y_q;
    fc_d    = fc_q;
    case (state_q)
      ST_IDLE: begin
        if (s_gfx_start) begin
          mode_d  = mode;
          solid_d = solid_color;
          hv_d    = h_visible;
          vv_d    = v_visible;
          x_d     = '0;
          y_d     = '0;
          // A zero-sized frame completes immediately without emitting pixels.
          state_d = dims_ok ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (m_gfx_ready) begin
          if (last_x) begin
            x_d = '0;
            if (last_y) begin
              y_d     = '0;
              fc_d    = fc_q + FRAME_CNT_WIDTH'(1);
              state_d = ST_DONE;
            end else begin
              y_d = y_q + V_WIDTH'(1);
            end
          end else begin
            x_d = x_q + H_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        if (continuous) begin
          mode_d  = mode;
          solid_d = solid_color;
          hv_d    = h_visible;
          vv_d    = v_visible;
          x_d     = '0;
          y_d     = '0;
          state_d = dims_ok ? ST_RUN : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      solid_q <= '0;
      hv_q    <= '0;
      vv_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      hv_q    <= hv_d;
      vv_q    <= vv_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
    end
  end

  // Pixel is a pure function of registered state, so it stays stable under
  // backpressure together with x/y.
  logic [COLOR_WIDTH-1:0] red, grn, blu;
  logic [COLOR_WIDTH-1:0] scroll;
  logic [2:0]             bar;

  always_comb begin
    scroll = x_q[COLOR_WIDTH-1:0] + y_q[COLOR_WIDTH-1:0] + fc_q[COLOR_WIDTH-1:0];
    bar    = x_q[BAR_SHIFT+2:BAR_SHIFT];
    red    = '0;
    grn    = '0;
    blu    = '0;
    case (mode_q)
      3'd0: {red, grn, blu} = solid_q;
      3'd1: begin
        red = {COLOR_WIDTH{bar[2]}};
        grn = {COLOR_WIDTH{bar[1]}};
        blu = {COLOR_WIDTH{bar[0]}};
      end
      3'd2: begin
        red = x_q[GRAD_SHIFT +: COLOR_WIDTH];
        grn = y_q[GRAD_SHIFT +: COLOR_WIDTH];
        blu = fc_q[COLOR_WIDTH-1:0];
      end
      3'd3: {red, grn, blu} = (x_q[CHECK_SHIFT] ^ y_q[CHECK_SHIFT]) ? ~solid_q : solid_q;
      3'd4: begin
        red = scroll;
        grn = ~scroll;
        blu = scroll;
      end
      default: ;
    endcase
  end

  assign m_gfx_pixel = {red, grn, blu};
  assign m_gfx_x     = x_q;
  assign m_gfx_y     = y_q;
  assign m_gfx_valid = (state_q == ST_RUN);
  assign busy        = (state_q == ST_RUN);
  assign s_gfx_done  = (state_q == ST_DONE);
  assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_gfx_pattern_gen.sv
// tb_gfx_pattern_gen: scoreboard bench for gfx_pattern_gen (default parameters).
module tb_gfx_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_gfx_start;
  logic        continuous;
  logic [2:0]  mode;
  logic [11:0] solid_color;
  logic [11:0] h_visible;
  logic [11:0] v_visible;
  logic        s_gfx_done;
  logic        busy;
  logic [7:0]  frame_cnt;
  logic        m_gfx_valid;
  logic [11:0] m_gfx_x;
  logic [11:0] m_gfx_y;
  logic [11:0] m_gfx_pixel;
  logic        m_gfx_ready;

  gfx_pattern_gen #(
    .H_WIDTH(12), .V_WIDTH(12), .COLOR_WIDTH(4), .PIXEL_WIDTH(12),
    .FRAME_CNT_WIDTH(8), .BAR_SHIFT(6), .CHECK_SHIFT(4), .GRAD_SHIFT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_gfx_start(s_gfx_start), .continuous(continuous),
    .mode(mode), .solid_color(solid_color), .h_visible(h_visible), .v_visible(v_visible),
    .s_gfx_done(s_gfx_done), .busy(busy), .frame_cnt(frame_cnt),
    .m_gfx_valid(m_gfx_valid), .m_gfx_x(m_gfx_x), .m_gfx_y(m_gfx_y),
    .m_gfx_pixel(m_gfx_pixel), .m_gfx_ready(m_gfx_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] pix;
  } beat_t;

  beat_t       sb[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          exp_fc       = 0;
  logic [11:0] pix_at_x [0:511];

  function automatic logic [11:0] model_pixel(input int md, input logic [11:0] sc,
                                              input int x, input int y, input int fc);
    int b, r, g, bl, s;
    r = 0; g = 0; bl = 0;
    case (md)
      0: return sc;
      1: begin
        b  = (x >> 6) % 8;
        r  = (b >= 4) ? 15 : 0;
        g  = ((b / 2) % 2 == 1) ? 15 : 0;
        bl = (b % 2 == 1) ? 15 : 0;
      end
      2: begin
        r  = (x >> 2) % 16;
        g  = (y >> 2) % 16;
        bl = fc % 16;
      end
      3: return ((((x >> 4) % 2) ^ ((y >> 4) % 2)) != 0) ? ~sc : sc;
      4: begin
        s  = (x + y + fc) % 16;
        r  = s;
        g  = 15 - s;
        bl = s;
      end
      default: ;
    endcase
    return 12'((r << 8) | (g << 4) | bl);
  endfunction

  task automatic push_frame(input int md, input logic [11:0] sc, input int hv,
                            input int vv, input int fc);
    for (int yy = 0; yy < vv; yy++)
      for (int xx = 0; xx < hv; xx++)
        sb.push_back('{x: 12'(xx), y: 12'(yy), pix: model_pixel(md, sc, xx, yy, fc)});
  endtask

  task automatic do_start();
    s_gfx_start = 1'b1;
    @(negedge clk);
    s_gfx_start = 1'b0;
  endtask

  // Runs the stream from the first valid cycle until the done pulse.
  // rdy_pat 0 = always ready, 1 = ready pattern 1,0,0,1 repeating.
  // Cycle index 0 is the first cycle after the start edge.
  task automatic run_frame(input int rdy_pat, input int glitch_cyc, input int budget,
                           output int done_cyc);
    beat_t got, prev, exp;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev       = '0;
    done_cyc   = -1;
    for (int c = 0; c < budget; c++) begin
      m_gfx_ready = (rdy_pat == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      s_gfx_start = (c == glitch_cyc);
      #1;
      got = '{x: m_gfx_x, y: m_gfx_y, pix: m_gfx_pixel};
      if (prev_stall) begin
        tests_run++;
        if (got !== prev) begin
          tests_failed++;
          $display("FAIL hold c=%0d: got %h required %h", c, got, prev);
        end
      end
      if (m_gfx_valid && m_gfx_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL extra_beat c=%0d: got %h required none", c, got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            tests_failed++;
            $display("FAIL beat c=%0d: got x=%0d y=%0d pix=%h required x=%0d y=%0d pix=%h",
                     c, got.x, got.y, got.pix, exp.x, exp.y, exp.pix);
          end
        end
        if (m_gfx_y == 12'd0 && m_gfx_x < 12'd512) pix_at_x[m_gfx_x[8:0]] = m_gfx_pixel;
      end
      prev_stall = m_gfx_valid && !m_gfx_ready;
      prev       = got;
      if (s_gfx_done) begin
        done_cyc = c;
        tests_run++;
        if (m_gfx_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL valid_in_done: got %b required 0", m_gfx_valid);
        end
      end
      @(negedge clk);
      if (done_cyc >= 0) break;
    end
    s_gfx_start = 1'b0;
    if (done_cyc < 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL done_timeout: got no done within %0d cycles required done", budget);
    end
  endtask

  task automatic check_end(input string nm, input int done_cyc, input int exp_done);
    tests_run++;
    if (done_cyc != exp_done || sb.size() != 0 || frame_cnt !== 8'(exp_fc)) begin
      tests_failed++;
      $display("FAIL %s_end: got done_cyc=%0d left=%0d fc=%0d required %0d 0 %0d",
               nm, done_cyc, sb.size(), frame_cnt, exp_done, exp_fc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({m_gfx_valid, s_gfx_done, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 000", {m_gfx_valid, s_gfx_done, busy});
    end
    tests_run++;
    if ({m_gfx_x, m_gfx_y, m_gfx_pixel, frame_cnt} !== 44'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got x=%0d y=%0d pix=%h fc=%0d required all 0",
               m_gfx_x, m_gfx_y, m_gfx_pixel, frame_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_solid();
    int dc;
    mode = 3'd0; solid_color = 12'hF00; h_visible = 12'd4; v_visible = 12'd2;
    push_frame(0, 12'hF00, 4, 2, exp_fc);
    do_start();
    run_frame(0, -1, 40, dc);
    exp_fc = (exp_fc + 1) % 256;
    check_end("solid", dc, 8);
    tests_run++;
    if ({busy, s_gfx_done, m_gfx_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL solid_idle: got %b required 000", {busy, s_gfx_done, m_gfx_valid});
    end
  endtask

  task automatic test_backpressure();
    int dc;
    mode = 3'd3; solid_color = 12'h5A3; h_visible = 12'd4; v_visible = 12'd2;
    push_frame(3, 12'h5A3, 4, 2, exp_fc);
    do_start();
    run_frame(1, -1, 60, dc);
    exp_fc = (exp_fc + 1) % 256;
    // Ready high on cycles 0,3,4,7,8,11,12,15: 8th handshake at 15.
    check_end("backpressure", dc, 16);
    m_gfx_ready = 1'b1;
  endtask

  task automatic test_bars();
    int dc;
    mode = 3'd1; h_visible = 12'd512; v_visible = 12'd1;
    push_frame(1, 12'h000, 512, 1, exp_fc);
    do_start();
    run_frame(0, -1, 600, dc);
    exp_fc = (exp_fc + 1) % 256;
    check_end("bars", dc, 512);
    tests_run++;
    if (pix_at_x[0] !== 12'h000 || pix_at_x[64] !== 12'h00F || pix_at_x[448] !== 12'hFFF) begin
      tests_failed++;
      $display("FAIL bars_spot: got %h %h %h required 000 00f fff",
               pix_at_x[0], pix_at_x[64], pix_at_x[448]);
    end
  endtask

  task automatic test_zero_dim();
    mode = 3'd0; h_visible = 12'd4; v_visible = 12'd0;
    do_start();
    #1;
    tests_run++;
    if ({s_gfx_done, m_gfx_valid, busy} !== 3'b100 || frame_cnt !== 8'(exp_fc)) begin
      tests_failed++;
      $display("FAIL zero_dim: got done/valid/busy=%b fc=%0d required 100 fc=%0d",
               {s_gfx_done, m_gfx_valid, busy}, frame_cnt, exp_fc);
    end
    @(negedge clk);
    tests_run++;
    if ({s_gfx_done, m_gfx_valid, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL zero_dim_idle: got %b required 000", {s_gfx_done, m_gfx_valid, busy});
    end
  endtask

  task automatic test_ignored_start();
    int dc;
    mode = 3'd2; solid_color = 12'h123; h_visible = 12'd4; v_visible = 12'd2;
    push_frame(2, 12'h123, 4, 2, exp_fc);
    do_start();
    // Inputs changed mid-frame must not affect the current frame.
    mode = 3'd0; solid_color = 12'h0F0; h_visible = 12'd2; v_visible = 12'd3;
    run_frame(0, 3, 40, dc);
    exp_fc = (exp_fc + 1) % 256;
    check_end("ignored_start", dc, 8);
  endtask

  task automatic test_continuous_scroll();
    int dc;
    mode = 3'd4; h_visible = 12'd2; v_visible = 12'd2; continuous = 1'b1;
    push_frame(4, 12'h000, 2, 2, exp_fc);
    do_start();
    for (int f = 0; f < 256; f++) begin
      if (f == 255) continuous = 1'b0;
      if (f > 0) push_frame(4, 12'h000, 2, 2, exp_fc);
      run_frame(0, -1, 20, dc);
      exp_fc = (exp_fc + 1) % 256;
      check_end("continuous", dc, 4);
    end
    tests_run++;
    if ({busy, s_gfx_done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL continuous_stop: got %b required 00", {busy, s_gfx_done});
    end
  endtask

  task automatic test_reset_mid_frame();
    int   dc;
    logic found;
    found = 1'b0;
    mode = 3'd0; solid_color = 12'h0AB; h_visible = 12'd4; v_visible = 12'd2;
    do_start();
    for (int c = 0; c < 20; c++) begin
      if (m_gfx_valid && m_gfx_x == 12'd2 && m_gfx_y == 12'd1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL reach_2_1: got not reached required (2,1)");
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({m_gfx_valid, s_gfx_done, busy} !== 3'b000 || frame_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: got valid/done/busy=%b fc=%0d required 000 fc=0",
               {m_gfx_valid, s_gfx_done, busy}, frame_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (s_gfx_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_done: got %b required 0", s_gfx_done);
    end
    sb.delete();
    exp_fc = 0;
    push_frame(0, 12'h0AB, 4, 2, exp_fc);
    do_start();
    run_frame(0, -1, 40, dc);
    exp_fc = 1;
    check_end("after_reset", dc, 8);
  endtask

  initial begin
    rst_n = 1'b0; s_gfx_start = 1'b0; continuous = 1'b0; mode = 3'd0;
    solid_color = 12'h000; h_visible = 12'd0; v_visible = 12'd0; m_gfx_ready = 1'b1;
    for (int i = 0; i < 512; i++) pix_at_x[i] = 12'hBAD;
    @(negedge clk);
    test_reset();
    test_solid();
    test_backpressure();
    test_bars();
    test_zero_dim();
    test_ignored_start();
    test_continuous_scroll();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
